// File: rtl/agc_pkg.sv
// Shared AGC definitions, imported by the AGC controller and the gain actuator.
// Contents:
//   agc_state_e     - two-bit actuator FSM encoding (IDLE / SETTLE / DONE)
//   AGC_GAIN_*      - default gain-code width, rails and reset value
//   AGC_SETTLE_CYC  - default post-step hold-off length in cycles
//   AGC_REV_LIMIT   - default number of consecutive reversals that declare convergence
//   AGC_SAT_LIMIT   - default number of consecutive blocked requests that declare convergence
package agc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } agc_state_e;

    localparam int AGC_GAIN_W     = 5;
    localparam int AGC_GAIN_MIN   = 0;
    localparam int AGC_GAIN_MAX   = 31;
    localparam int AGC_GAIN_INIT  = 16;
    localparam int AGC_SETTLE_CYC = 8;
    localparam int AGC_REV_LIMIT  = 3;
    localparam int AGC_SAT_LIMIT  = 2;

endpackage : agc_pkg

// File: rtl/agc_gain_actuator_if.sv
// Controller <-> gain actuator link.
// Controller to actuator:
//   adjust      - high for the whole adjust phase of the controller
//   up_dn       - 1 = raise gain, 0 = lower gain; valid while adjust is high
//   restart     - synchronous clear of convergence state (gain_code is kept)
// Actuator to controller / analog front end:
//   gain_code   - registered gain setting
//   gain_update - one-cycle strobe, gain_code changed this cycle
//   settling    - high during the post-step hold-off
//   sat_hi      - gain_code is at the upper rail
//   sat_lo      - gain_code is at the lower rail
//   done        - sticky convergence flag
interface agc_gain_actuator_if #(
    parameter int GAIN_W = agc_pkg::AGC_GAIN_W
);
    logic              adjust;
    logic              up_dn;
    logic              restart;
    logic [GAIN_W-1:0] gain_code;
    logic              gain_update;
    logic              settling;
    logic              sat_hi;
    logic              sat_lo;
    logic              done;

    modport master (
        output adjust, up_dn, restart,
        input  gain_code, gain_update, settling, sat_hi, sat_lo, done
    );

    modport slave (
        input  adjust, up_dn, restart,
        output gain_code, gain_update, settling, sat_hi, sat_lo, done
    );
endinterface : agc_gain_actuator_if

// File: rtl/agc_sat_step.sv
// Combinational saturating +/-1 step of a gain code.
// Ports:
//   code_i    - current gain code
//   up_i      - 1 = step up, 0 = step down
//   code_o    - stepped code, clamped to [GAIN_MIN, GAIN_MAX]
//   blocked_o - the request pushed against a rail, so code_o == code_i
module agc_sat_step #(
    parameter int GAIN_W   = agc_pkg::AGC_GAIN_W,
    parameter int GAIN_MIN = agc_pkg::AGC_GAIN_MIN,
    parameter int GAIN_MAX = agc_pkg::AGC_GAIN_MAX
) (
    input  logic [GAIN_W-1:0] code_i,
    input  logic              up_i,
    output logic [GAIN_W-1:0] code_o,
    output logic              blocked_o
);
    localparam logic [GAIN_W-1:0] MIN_C = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0] MAX_C = GAIN_W'(GAIN_MAX);

    // NOTE: every output gets a default before any branch so the block stays
    // purely combinational; a path that skips an assignment would infer a latch.
    always_comb begin
        code_o    = code_i;
        blocked_o = 1'b0;
        if (up_i) begin
            if (code_i >= MAX_C) blocked_o = 1'b1;
            else                 code_o    = code_i + 1'b1;
        end else begin
            if (code_i <= MIN_C) blocked_o = 1'b1;
            else                 code_o    = code_i - 1'b1;
        end
    end
endmodule : agc_sat_step

// File: rtl/agc_gain_actuator.sv
// AGC gain actuator: receiving end of the controller's adjust/up_dn link.
// Each rising edge of adjust (seen while idle) becomes one saturating gain step,
// followed by a SETTLE_CYC-cycle hold-off. Convergence (REV_LIMIT consecutive
// direction reversals, or SAT_LIMIT consecutive requests against a rail) freezes
// the gain and raises a sticky done until restart or reset.
// Ports:
//   clk    - system clock
//   RESETn - asynchronous active-low reset
//   bus    - slave side of agc_gain_actuator_if (adjust/up_dn/restart in,
//            gain_code/gain_update/settling/sat_hi/sat_lo/done out)
module agc_gain_actuator
    import agc_pkg::*;
#(
    parameter int GAIN_W     = AGC_GAIN_W,
    parameter int GAIN_MIN   = AGC_GAIN_MIN,
    parameter int GAIN_MAX   = AGC_GAIN_MAX,
    parameter int GAIN_INIT  = AGC_GAIN_INIT,
    parameter int SETTLE_CYC = AGC_SETTLE_CYC,
    parameter int REV_LIMIT  = AGC_REV_LIMIT,
    parameter int SAT_LIMIT  = AGC_SAT_LIMIT
) (
    input  logic               clk,
    input  logic               RESETn,
    agc_gain_actuator_if.slave bus
);
    localparam int REV_W = $clog2(REV_LIMIT + 1);
    localparam int SAT_W = $clog2(SAT_LIMIT + 1);
    localparam int SET_W = 4;

    localparam logic [GAIN_W-1:0] INIT_C    = GAIN_W'(GAIN_INIT);
    localparam logic [GAIN_W-1:0] MIN_C     = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0] MAX_C     = GAIN_W'(GAIN_MAX);
    localparam logic [REV_W-1:0]  REV_MAX   = REV_W'(REV_LIMIT);
    localparam logic [SAT_W-1:0]  SAT_MAX   = SAT_W'(SAT_LIMIT);
    localparam logic [SET_W-1:0]  SET_START = SET_W'(SETTLE_CYC - 1);

    agc_state_e        state_q, state_d;
    logic              adj_q;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              upd_q, upd_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic [SAT_W-1:0]  sat_q, sat_d;
    logic              have_dir_q, have_dir_d;
    logic              last_dir_q, last_dir_d;

    logic              rise;
    logic [GAIN_W-1:0] stepped;
    logic              blocked;

    // adj_q is cleared by reset, so adjust already high right after reset is a rise.
    assign rise = bus.adjust & ~adj_q;

    agc_sat_step #(
        .GAIN_W   (GAIN_W),
        .GAIN_MIN (GAIN_MIN),
        .GAIN_MAX (GAIN_MAX)
    ) u_sat_step (
        .code_i    (gain_q),
        .up_i      (bus.up_dn),
        .code_o    (stepped),
        .blocked_o (blocked)
    );

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        upd_d      = 1'b0;
        settle_d   = settle_q;
        rev_d      = rev_q;
        sat_d      = sat_q;
        have_dir_d = have_dir_q;
        last_dir_d = last_dir_q;

        if (bus.restart) begin
            // restart wins over a simultaneous rise: no step this cycle.
            state_d    = ST_IDLE;
            rev_d      = '0;
            sat_d      = '0;
            have_dir_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        if (have_dir_q && (bus.up_dn != last_dir_q))
                            rev_d = (rev_q == REV_MAX) ? rev_q : rev_q + 1'b1;
                        else
                            rev_d = '0;
                        if (blocked)
                            sat_d = (sat_q == SAT_MAX) ? sat_q : sat_q + 1'b1;
                        else
                            sat_d = '0;
                        last_dir_d = bus.up_dn;
                        have_dir_d = 1'b1;

                        // The converging request itself does not move the gain.
                        if ((rev_d >= REV_MAX) || (sat_d >= SAT_MAX)) begin
                            state_d = ST_DONE;
                        end else begin
                            gain_d   = stepped;
                            upd_d    = ~blocked;
                            settle_d = SET_START;
                            state_d  = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Counter runs SETTLE_CYC-1 .. 0, i.e. SETTLE_CYC cycles in this state.
                    if (settle_q == '0) state_d  = ST_IDLE;
                    else                settle_d = settle_q - 1'b1;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of block evaluation order.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            adj_q      <= 1'b0;
            gain_q     <= INIT_C;
            upd_q      <= 1'b0;
            settle_q   <= '0;
            rev_q      <= '0;
            sat_q      <= '0;
            have_dir_q <= 1'b0;
            last_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adj_q      <= bus.adjust;
            gain_q     <= gain_d;
            upd_q      <= upd_d;
            settle_q   <= settle_d;
            rev_q      <= rev_d;
            sat_q      <= sat_d;
            have_dir_q <= have_dir_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign bus.gain_code   = gain_q;
    assign bus.gain_update = upd_q;
    assign bus.settling    = (state_q == ST_SETTLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.sat_hi      = (gain_q == MAX_C);
    assign bus.sat_lo      = (gain_q == MIN_C);

endmodule : agc_gain_actuator

// File: tb/tb_agc_gain_actuator.sv
// Testbench for agc_gain_actuator. Two instances share one stimulus stream:
// dut_a with default parameters (GAIN_INIT=16) and dut_b with GAIN_INIT=30.
// A behavioural model of each instance is compared against the DUT outputs on
// every falling clock edge; directed sequences add literal expectations.
module tb_agc_gain_actuator;
    import agc_pkg::*;

    localparam int GMIN   = 0;
    localparam int GMAX   = 31;
    localparam int SETTLE = 8;
    localparam int REVL   = 3;
    localparam int SATL   = 2;
    localparam int INIT_G [2] = '{16, 30};

    logic clk = 1'b0;
    logic rst_n;
    logic adjust  = 1'b0;
    logic up_dn   = 1'b0;
    logic restart = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    agc_gain_actuator_if #(.GAIN_W(5)) bus_a ();
    agc_gain_actuator_if #(.GAIN_W(5)) bus_b ();

    assign bus_a.adjust  = adjust;
    assign bus_a.up_dn   = up_dn;
    assign bus_a.restart = restart;
    assign bus_b.adjust  = adjust;
    assign bus_b.up_dn   = up_dn;
    assign bus_b.restart = restart;

    agc_gain_actuator dut_a (
        .clk    (clk),
        .RESETn (rst_n),
        .bus    (bus_a)
    );

    agc_gain_actuator #(.GAIN_INIT(30)) dut_b (
        .clk    (clk),
        .RESETn (rst_n),
        .bus    (bus_b)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int gain;
        int hold;   // hold-off cycles still to run
        int rev;
        int sat;
        bit done;
        bit have;
        bit last;
        bit prev;   // adjust as seen on the previous clock
        bit upd;
    } model_t;

    model_t m [2];

    function automatic model_t model_reset(int k);
        model_t n;
        n.gain = INIT_G[k];
        n.hold = 0;
        n.rev  = 0;
        n.sat  = 0;
        n.done = 1'b0;
        n.have = 1'b0;
        n.last = 1'b0;
        n.prev = 1'b0;
        n.upd  = 1'b0;
        return n;
    endfunction

    function automatic model_t model_step(model_t s, bit adj, bit up, bit rs);
        model_t n = s;
        bit rise = adj && !s.prev;
        int target;
        bit blk;
        n.prev = adj;
        n.upd  = 1'b0;
        if (rs) begin
            n.done = 1'b0;
            n.hold = 0;
            n.rev  = 0;
            n.sat  = 0;
            n.have = 1'b0;
        end else if (!s.done) begin
            if (s.hold > 0) begin
                n.hold = s.hold - 1;
            end else if (rise) begin
                target = up ? s.gain + 1 : s.gain - 1;
                blk    = (target > GMAX) || (target < GMIN);
                n.rev  = (s.have && (up != s.last)) ? ((s.rev + 1 > REVL) ? REVL : s.rev + 1) : 0;
                n.sat  = blk ? ((s.sat + 1 > SATL) ? SATL : s.sat + 1) : 0;
                n.last = up;
                n.have = 1'b1;
                if (n.rev >= REVL || n.sat >= SATL) begin
                    n.done = 1'b1;
                end else begin
                    if (!blk) begin
                        n.gain = target;
                        n.upd  = 1'b1;
                    end
                    n.hold = SETTLE;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) m[k] <= model_reset(k);
            else        m[k] <= model_step(m[k], adjust, up_dn, restart);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string p, input model_t e, input logic [4:0] g,
                           input logic u, input logic s, input logic hi,
                           input logic lo, input logic d);
        check({p, ".gain_code"},   32'(g),  32'(e.gain));
        check({p, ".gain_update"}, 32'(u),  32'(e.upd));
        check({p, ".settling"},    32'(s),  32'(e.hold > 0));
        check({p, ".sat_hi"},      32'(hi), 32'(e.gain == GMAX));
        check({p, ".sat_lo"},      32'(lo), 32'(e.gain == GMIN));
        check({p, ".done"},        32'(d),  32'(e.done));
    endtask

    always @(negedge clk) begin
        cmp_dut("a", m[0], bus_a.gain_code, bus_a.gain_update, bus_a.settling,
                bus_a.sat_hi, bus_a.sat_lo, bus_a.done);
        cmp_dut("b", m[1], bus_b.gain_code, bus_b.gain_update, bus_b.settling,
                bus_b.sat_hi, bus_b.sat_lo, bus_b.done);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        adjust  = 1'b0;
        up_dn   = 1'b0;
        restart = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // One adjust episode: 2 cycles high, 10 low (longer than the hold-off).
    task automatic episode(input logic up, output int upd_a, output int upd_b);
        upd_a  = 0;
        upd_b  = 0;
        adjust = 1'b1;
        up_dn  = up;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (i == 1) adjust = 1'b0;
            upd_a += int'(bus_a.gain_update);
            upd_b += int'(bus_b.gain_update);
        end
    endtask

    int ua, ub, n_set, n_upd;
    int pct;

    initial begin
        rst_n = 1'b0;

        // Reset values.
        do_reset();
        check("rst.a.gain", 32'(bus_a.gain_code), 16);
        check("rst.b.gain", 32'(bus_b.gain_code), 30);
        check("rst.a.flags", {28'd0, bus_a.gain_update, bus_a.settling, bus_a.done, bus_a.sat_hi}, 0);

        // Long adjust level: exactly one step, one strobe, 8 settling cycles.
        adjust = 1'b1;
        up_dn  = 1'b1;
        n_set  = 0;
        n_upd  = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (i == 0) begin
                check("t1.gain_after_rise", 32'(bus_a.gain_code), 17);
                check("t1.update_after_rise", 32'(bus_a.gain_update), 1);
            end
            n_set += int'(bus_a.settling);
            n_upd += int'(bus_a.gain_update);
        end
        check("t1.settle_cycles", 32'(n_set), 8);
        check("t1.update_pulses", 32'(n_upd), 1);
        check("t1.gain_final", 32'(bus_a.gain_code), 17);
        adjust = 1'b0;
        cyc(2);

        // Reversals up,down,up,down: the fourth request declares done.
        do_reset();
        episode(1'b1, ua, ub);
        check("t2.gain1", 32'(bus_a.gain_code), 17);
        check("t2.upd1", 32'(ua), 1);
        episode(1'b0, ua, ub);
        check("t2.gain2", 32'(bus_a.gain_code), 16);
        episode(1'b1, ua, ub);
        check("t2.gain3", 32'(bus_a.gain_code), 17);
        episode(1'b0, ua, ub);
        check("t2.gain4", 32'(bus_a.gain_code), 17);
        check("t2.upd4", 32'(ua), 0);
        check("t2.done", 32'(bus_a.done), 1);
        episode(1'b1, ua, ub);
        check("t2.ignored_gain", 32'(bus_a.gain_code), 17);
        check("t2.ignored_done", 32'(bus_a.done), 1);

        // Restart together with a rise while done: cleared, no step.
        adjust  = 1'b1;
        up_dn   = 1'b1;
        restart = 1'b1;
        cyc(1);
        check("t5.done", 32'(bus_a.done), 0);
        check("t5.upd", 32'(bus_a.gain_update), 0);
        check("t5.gain", 32'(bus_a.gain_code), 17);
        restart = 1'b0;
        cyc(3);
        check("t5.gain_held", 32'(bus_a.gain_code), 17);
        check("t5.settling", 32'(bus_a.settling), 0);
        adjust = 1'b0;
        cyc(2);

        // Re-raise inside the hold-off is dropped; a later rise is accepted.
        adjust = 1'b1;
        up_dn  = 1'b0;
        cyc(1);
        check("t4.gain_first", 32'(bus_a.gain_code), 16);
        adjust = 1'b0;
        cyc(2);
        adjust = 1'b1;
        cyc(2);
        check("t4.gain_in_settle", 32'(bus_a.gain_code), 16);
        adjust = 1'b0;
        cyc(8);
        check("t4.idle", 32'(bus_a.settling), 0);
        adjust = 1'b1;
        cyc(1);
        check("t4.gain_second", 32'(bus_a.gain_code), 15);
        adjust = 1'b0;
        cyc(10);

        // Asynchronous reset in the middle of the hold-off.
        adjust = 1'b1;
        up_dn  = 1'b0;
        cyc(3);
        check("t6.gain_before", 32'(bus_a.gain_code), 14);
        check("t6.settling_before", 32'(bus_a.settling), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.a.gain", 32'(bus_a.gain_code), 16);
        check("t6.a.settling", 32'(bus_a.settling), 0);
        check("t6.b.gain", 32'(bus_b.gain_code), 30);
        @(negedge clk);
        adjust = 1'b0;
        rst_n  = 1'b1;
        cyc(1);

        // Upper rail on dut_b: 30 -> 31, then two blocked requests declare done.
        episode(1'b1, ua, ub);
        check("t3.b.gain1", 32'(bus_b.gain_code), 31);
        check("t3.b.sat_hi", 32'(bus_b.sat_hi), 1);
        check("t3.b.upd1", 32'(ub), 1);
        episode(1'b1, ua, ub);
        check("t3.b.upd2", 32'(ub), 0);
        check("t3.b.done2", 32'(bus_b.done), 0);
        episode(1'b1, ua, ub);
        check("t3.b.upd3", 32'(ub), 0);
        check("t3.b.done3", 32'(bus_b.done), 1);
        check("t3.b.gain3", 32'(bus_b.gain_code), 31);
        check("t3.a.gain3", 32'(bus_a.gain_code), 19);

        // Randomised traffic with direction bias phases so both rails get hit.
        for (int c = 0; c < 4000; c++) begin
            case ((c / 500) % 3)
                0:       pct = 85;
                1:       pct = 15;
                default: pct = 50;
            endcase
            if ($urandom_range(0, 3) == 0) adjust = ~adjust;
            up_dn   = ($urandom_range(0, 99) < pct);
            restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        adjust  = 1'b0;
        restart = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_agc_gain_actuator
